search_ram_arbiter: RTL and testbench

Shares the single-port search RAM among three requesters: the array loader, the binary-search engine and the host/debug reader. Each cycle it picks one requester by rotating priority and drives that requester's address, write enable and write data onto the RAM port. Read data returns one cycle later, tagged to the requester that issued the read. A lock input lets the search engine keep the port across consecutive memgrab cycles, bounded by a hold limit.

---
 rtl/search_mem_pkg.sv | 32 +++
 rtl/rr_priority_picker.sv | 35 +++
 rtl/search_ram_arbiter.sv | 128 ++++++++++++
 tb/tb_search_ram_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/search_mem_pkg.sv
// Shared constants, requester indices and FSM state encoding for the
// search RAM port arbiter.
package search_mem_pkg;

  localparam int N_REQ  = 3;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int IDX_W  = 2;

  localparam logic [IDX_W-1:0] REQ_LOADER = 2'd0;
  localparam logic [IDX_W-1:0] REQ_SEARCH = 2'd1;
  localparam logic [IDX_W-1:0] REQ_HOST   = 2'd2;

  typedef logic [0:0] state_t;
  localparam state_t S_IDLE = 1'b0;
  localparam state_t S_OWN  = 1'b1;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] nxt;
    if (idx == IDX_W'(N_REQ - 1)) begin
      nxt = '0;
    end else begin
      nxt = idx + IDX_W'(1);
    end
    return nxt;
  endfunction

  function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority picker: first eligible requester at or
// after rr_ptr, wrapping, with an exclusion mask.
module rr_priority_picker
  import search_mem_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  input  logic [N_REQ-1:0] exclude,
  output logic [N_REQ-1:0] sel_onehot,
  output logic [IDX_W-1:0] sel_idx,
  output logic             sel_valid
);

  logic [N_REQ-1:0] eligible_s;
  logic [IDX_W-1:0] scan_s;
  logic             hit_s;

  // Walk the ring once from rr_ptr; the first eligible hit wins.
  always_comb begin
    eligible_s = req & ~exclude;
    sel_onehot = '0;
    sel_idx    = '0;
    sel_valid  = 1'b0;
    hit_s      = 1'b0;
    scan_s     = rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      hit_s      = !sel_valid && eligible_s[scan_s];
      sel_idx    = hit_s ? scan_s : sel_idx;
      sel_onehot = hit_s ? idx_onehot(scan_s) : sel_onehot;
      sel_valid  = sel_valid | hit_s;
      scan_s     = next_idx(scan_s);
    end
  end

endmodule

// File: rtl/search_ram_arbiter.sv
// Single-port search RAM arbiter: rotating priority among loader, search
// engine and host, with bounded lock ownership and a 1-cycle read tag.
module search_ram_arbiter
  import search_mem_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        lock,
  input  logic [N_REQ-1:0]        we,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  input  logic [N_REQ*DATA_W-1:0] wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic                    ram_we,
  output logic [DATA_W-1:0]       ram_wdata,
  input  logic [DATA_W-1:0]       ram_rdata,
  output logic                    busy
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  state_t            state_r, state_n;
  logic [IDX_W-1:0]  owner_r, owner_n;
  logic [HOLD_W-1:0] hold_r, hold_n;
  logic [IDX_W-1:0]  rr_ptr_r, rr_ptr_n;
  logic [N_REQ-1:0]  rvalid_r;

  logic              keep_s;
  logic [N_REQ-1:0]  exclude_s;
  logic [N_REQ-1:0]  pick_onehot_s;
  logic [IDX_W-1:0]  pick_idx_s;
  logic              pick_valid_s;
  logic [N_REQ-1:0]  gnt_s;
  logic [IDX_W-1:0]  sel_s;

  // An owner that has used up its hold budget sits out the re-arbitration.
  assign keep_s    = (state_r == S_OWN) && req[owner_r] && (hold_r < HOLD_W'(MAX_HOLD));
  assign exclude_s = ((state_r == S_OWN) && (hold_r >= HOLD_W'(MAX_HOLD))) ?
                     idx_onehot(owner_r) : '0;

  rr_priority_picker u_picker (
    .req        (req),
    .rr_ptr     (rr_ptr_r),
    .exclude    (exclude_s),
    .sel_onehot (pick_onehot_s),
    .sel_idx    (pick_idx_s),
    .sel_valid  (pick_valid_s)
  );

  // Grant selection and next-state for FSM, owner, hold and rr_ptr.
  always_comb begin
    state_n  = S_IDLE;
    owner_n  = owner_r;
    hold_n   = '0;
    rr_ptr_n = rr_ptr_r;
    gnt_s    = '0;
    sel_s    = '0;
    if (keep_s) begin
      gnt_s = idx_onehot(owner_r);
      sel_s = owner_r;
      if (lock[owner_r]) begin
        state_n = S_OWN;
        hold_n  = hold_r + HOLD_W'(1);
      end else begin
        state_n = S_IDLE;
        hold_n  = '0;
      end
    end else if (pick_valid_s) begin
      gnt_s    = pick_onehot_s;
      sel_s    = pick_idx_s;
      rr_ptr_n = next_idx(pick_idx_s);
      if (lock[pick_idx_s]) begin
        state_n = S_OWN;
        owner_n = pick_idx_s;
        hold_n  = HOLD_W'(1);
      end else begin
        state_n = S_IDLE;
        hold_n  = '0;
      end
    end else begin
      state_n = S_IDLE;
      hold_n  = '0;
    end
  end

  // RAM port mux; everything parks at zero when nothing is granted or in reset.
  always_comb begin
    if (reset || (gnt_s == '0)) begin
      gnt       = '0;
      ram_addr  = '0;
      ram_we    = 1'b0;
      ram_wdata = '0;
    end else begin
      gnt       = gnt_s;
      ram_addr  = addr[sel_s*ADDR_W +: ADDR_W];
      ram_we    = we[sel_s];
      ram_wdata = wdata[sel_s*DATA_W +: DATA_W];
    end
  end

  // Arbiter state and read-tag pipeline.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= S_IDLE;
      owner_r  <= '0;
      hold_r   <= '0;
      rr_ptr_r <= '0;
      rvalid_r <= '0;
    end else begin
      state_r  <= state_n;
      owner_r  <= owner_n;
      hold_r   <= hold_n;
      rr_ptr_r <= rr_ptr_n;
      rvalid_r <= gnt_s & ~we;
    end
  end

  // A tag registered just before reset must not leak out while reset is high.
  assign rvalid = reset ? '0 : rvalid_r;
  assign busy   = !reset && (state_r == S_OWN);
  assign rdata  = ram_rdata;

endmodule

// File: tb/tb_search_ram_arbiter.sv
// Directed and randomized check of search_ram_arbiter against a behavioural
// arbitration model with a shadow RAM.
module tb_search_ram_arbiter;

  localparam int MAX_HOLD = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req = '0, lock = '0, we = '0;
  logic [14:0] addr = '0;
  logic [23:0] wdata = '0;
  logic [2:0]  gnt, rvalid;
  logic [7:0]  rdata, ram_wdata;
  logic [7:0]  ram_rdata = '0;
  logic [4:0]  ram_addr;
  logic        ram_we, busy;

  logic [7:0]  mem [32];
  logic [7:0]  shadow [32];

  int n_vec = 0, n_bad = 0;
  int m_own = -1, m_hold = 0, m_rr = 0, m_prev_rd = -1, m_last_g = -1;
  logic [7:0] m_prev_data = '0;

  search_ram_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clock(clock), .reset(reset), .req(req), .lock(lock), .we(we),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  // Synchronous single-port RAM, 1-cycle read latency.
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, predict from the arbitration rules, compare, advance model.
  task automatic apply(input logic rst, input logic [2:0] r, input logic [2:0] l,
                       input logic [2:0] w, input logic [14:0] a, input logic [23:0] d);
    int g, excl, idx, own_n, hold_n, rr_n;
    logic [2:0] e_gnt, e_rv;
    logic [4:0] e_addr;
    logic [7:0] e_wd;
    logic       e_we;
    @(negedge clock);
    reset = rst; req = r; lock = l; we = w; addr = a; wdata = d;
    #1;
    g = -1; own_n = m_own; hold_n = m_hold; rr_n = m_rr;
    if (rst) begin
      own_n = -1; hold_n = 0; rr_n = 0;
    end else if (m_own >= 0 && r[m_own] && m_hold < MAX_HOLD) begin
      g = m_own; hold_n = m_hold + 1;
      if (!l[m_own]) begin own_n = -1; hold_n = 0; end
    end else begin
      excl = (m_own >= 0 && m_hold >= MAX_HOLD) ? m_own : -1;
      for (int k = 0; k < 3; k++) begin
        idx = (m_rr + k) % 3;
        if (g < 0 && r[idx] && idx != excl) g = idx;
      end
      own_n = -1; hold_n = 0;
      if (g >= 0) begin
        rr_n = (g + 1) % 3;
        if (l[g]) begin own_n = g; hold_n = 1; end
      end
    end
    e_gnt  = (g >= 0) ? 3'(1 << g) : 3'b000;
    e_addr = (g >= 0) ? a[g*5 +: 5] : 5'd0;
    e_wd   = (g >= 0) ? d[g*8 +: 8] : 8'd0;
    e_we   = (g >= 0) ? w[g] : 1'b0;
    e_rv   = (!rst && m_prev_rd >= 0) ? 3'(1 << m_prev_rd) : 3'b000;
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    check("ram_we", 32'(ram_we), 32'(e_we));
    check("ram_addr", 32'(ram_addr), 32'(e_addr));
    check("ram_wdata", 32'(ram_wdata), 32'(e_wd));
    check("busy", 32'(busy), 32'(!rst && m_own >= 0));
    check("rvalid", 32'(rvalid), 32'(e_rv));
    if (e_rv != 3'b000) check("rdata", 32'(rdata), 32'(m_prev_data));
    m_prev_rd = -1;
    if (g >= 0 && !w[g]) begin
      m_prev_rd = g; m_prev_data = shadow[e_addr];
    end
    if (g >= 0 && w[g]) shadow[e_addr] = e_wd;
    m_own = own_n; m_hold = hold_n; m_rr = rr_n; m_last_g = g;
  endtask

  initial begin
    logic [2:0]  pend, rl, rw;
    logic [14:0] ra;
    logic [23:0] rd;
    for (int i = 0; i < 32; i++) begin
      mem[i] = 8'($urandom);
      shadow[i] = mem[i];
    end

    apply(1'b1, 3'b000, 3'b000, 3'b000, 15'd0, 24'd0);
    apply(1'b1, 3'b111, 3'b111, 3'b000, 15'd0, 24'd0);

    // Plain rotation with all three requesting.
    apply(1'b0, 3'b111, 3'b000, 3'b000, {5'd20, 5'd10, 5'd5}, 24'd0);
    check("rot0", 32'(gnt), 32'(3'b001));
    apply(1'b0, 3'b111, 3'b000, 3'b000, {5'd21, 5'd11, 5'd6}, 24'd0);
    check("rot1", 32'(gnt), 32'(3'b010));
    apply(1'b0, 3'b111, 3'b000, 3'b000, {5'd22, 5'd12, 5'd7}, 24'd0);
    check("rot2", 32'(gnt), 32'(3'b100));

    // Search holds the port for three reads while host waits.
    apply(1'b0, 3'b110, 3'b010, 3'b000, {5'd7, 5'd16, 5'd0}, 24'd0);
    check("lock0", 32'(gnt), 32'(3'b010));
    apply(1'b0, 3'b110, 3'b010, 3'b000, {5'd7, 5'd8, 5'd0}, 24'd0);
    check("lock1", 32'(gnt), 32'(3'b010));
    apply(1'b0, 3'b110, 3'b000, 3'b000, {5'd7, 5'd12, 5'd0}, 24'd0);
    check("lock2", 32'(gnt), 32'(3'b010));
    apply(1'b0, 3'b100, 3'b000, 3'b000, {5'd7, 5'd12, 5'd0}, 24'd0);
    check("lock_rel", 32'(gnt), 32'(3'b100));

    // Hold limit: loader, 8 search grants, forced hand-back to loader.
    for (int i = 0; i < 11; i++) begin
      apply(1'b0, 3'b011, 3'b010, 3'b000, {5'd1, 5'(i), 5'd2}, 24'd0);
      check("hold_seq", 32'(gnt), (i == 0 || i == 9) ? 32'(3'b001) : 32'(3'b010));
    end

    // Write then read back through the host.
    apply(1'b0, 3'b001, 3'b000, 3'b001, {5'd0, 5'd0, 5'd3}, {8'd0, 8'd0, 8'hA5});
    check("wr_we", 32'(ram_we), 32'd1);
    apply(1'b0, 3'b100, 3'b000, 3'b000, {5'd3, 5'd0, 5'd0}, 24'd0);
    apply(1'b0, 3'b000, 3'b000, 3'b000, 15'd0, 24'd0);
    check("rd_rvalid", 32'(rvalid), 32'(3'b100));
    check("rd_data", 32'(rdata), 32'(8'hA5));

    // Reset landing on a pending read while search owns the port.
    apply(1'b0, 3'b010, 3'b010, 3'b000, {5'd0, 5'd9, 5'd0}, 24'd0);
    apply(1'b1, 3'b010, 3'b010, 3'b000, {5'd0, 5'd9, 5'd0}, 24'd0);
    check("rst_rvalid", 32'(rvalid), 32'(3'b000));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gnt", 32'(gnt), 32'(3'b000));
    apply(1'b0, 3'b110, 3'b000, 3'b000, {5'd4, 5'd9, 5'd0}, 24'd0);
    check("post_rst", 32'(gnt), 32'(3'b010));

    // Owner drops req with loader waiting: same-cycle hand-over.
    apply(1'b0, 3'b010, 3'b010, 3'b000, {5'd0, 5'd13, 5'd0}, 24'd0);
    apply(1'b0, 3'b001, 3'b000, 3'b000, {5'd0, 5'd13, 5'd14}, 24'd0);
    check("drop_handover", 32'(gnt), 32'(3'b001));

    // Randomized traffic; requests stay up with fixed fields until granted.
    pend = '0; rl = '0; rw = '0; ra = '0; rd = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && ($urandom % 3 == 0)) begin
          pend[i] = 1'b1;
          rw[i] = ($urandom % 4 == 0);
          ra[i*5 +: 5] = 5'($urandom);
          rd[i*8 +: 8] = 8'($urandom);
        end
        rl[i] = (i == 1) ? ($urandom % 4 != 0) : ($urandom % 3 == 0);
      end
      apply(($urandom % 200) == 0, pend, rl, rw, ra, rd);
      if (m_last_g >= 0 && ($urandom % 2 == 0)) pend[m_last_g] = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
